// File: rtl/up_counter_ctrl_pkg.sv
// Shared definitions for the up_counter_ctrl sequencing controller.
package up_counter_ctrl_pkg;

  // Controller state encoding.
  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'b00;
  localparam state_t S_RUN   = 2'b01;
  localparam state_t S_PAUSE = 2'b10;
  localparam state_t S_DONE  = 2'b11;

endpackage : up_counter_ctrl_pkg

// File: rtl/ctrl_up_counter.sv
// N-bit up counter with synchronous clear (dominant) and count enable.
module ctrl_up_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [N-1:0] q
);

  // Count register: clear wins over enable so a reload never also increments.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + N'(1);
    end
  end

endmodule : ctrl_up_counter

// File: rtl/up_counter_ctrl.sv
// Sequencing controller around an N-bit up counter: start/halt control,
// programmable prescaler, programmable terminal limit, one-shot or periodic.
module up_counter_ctrl
  import up_counter_ctrl_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          halt,
  input  logic          periodic,
  input  logic [N-1:0]  limit,
  input  logic [PW-1:0] prescale,
  output logic [N-1:0]  Q,
  output logic          busy,
  output logic          tc,
  output logic          done
);

  state_t        state;
  state_t        state_next;

  logic [N-1:0]  limit_l;
  logic [PW-1:0] prescale_l;
  logic          periodic_l;
  logic [PW-1:0] psc;

  logic          in_run;
  logic          tick;
  logic          at_limit;
  logic          terminal;
  logic          load;
  logic          abort;
  logic          cnt_clr;
  logic          cnt_en;

  logic          busy_d;
  logic          done_d;
  logic          tc_d;

  // Event decode shared by the FSM, prescaler and counter. halt beats start
  // everywhere, and a halted RUN cycle never produces a tick.
  always_comb begin
    in_run   = (state == S_RUN);
    tick     = in_run && !halt && (psc == prescale_l);
    at_limit = (Q == limit_l);
    terminal = tick && at_limit;
    load     = ((state == S_IDLE) || (state == S_DONE)) && start && !halt;
    abort    = ((state == S_PAUSE) || (state == S_DONE)) && halt;
    cnt_clr  = load || abort || (terminal && periodic_l);
    cnt_en   = tick && !at_limit;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      S_IDLE:  if (load) state_next = S_RUN;
      S_RUN: begin
        if (halt) begin
          state_next = S_PAUSE;
        end else if (terminal && !periodic_l) begin
          state_next = S_DONE;
        end
      end
      S_PAUSE: begin
        if (halt) begin
          state_next = S_IDLE;
        end else if (start) begin
          state_next = S_RUN;
        end
      end
      S_DONE: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (load) begin
          state_next = S_RUN;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with it.
  always_comb begin
    busy_d = (state_next == S_RUN) || (state_next == S_PAUSE);
    done_d = (state_next == S_DONE);
    tc_d   = terminal;
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      tc   <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      tc   <= tc_d;
    end
  end

  // Configuration latches: captured only when a run is (re)started from IDLE/DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      limit_l    <= '0;
      prescale_l <= '0;
      periodic_l <= 1'b0;
    end else if (load) begin
      limit_l    <= limit;
      prescale_l <= prescale;
      periodic_l <= periodic;
    end
  end

  // Prescaler: counts 0..prescale_l while running, frozen in PAUSE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psc <= '0;
    end else if (load || abort) begin
      psc <= '0;
    end else if (in_run && !halt) begin
      psc <= (psc == prescale_l) ? '0 : psc + PW'(1);
    end
  end

  ctrl_up_counter #(
    .N (N)
  ) u_count (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .q       (Q)
  );

endmodule : up_counter_ctrl

// File: tb/tb_up_counter_ctrl.sv
// Directed testbench for up_counter_ctrl (N=4, PW=4, 10ns clock).
module tb_up_counter_ctrl;

  localparam int N  = 4;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          halt;
  logic          periodic;
  logic [N-1:0]  limit;
  logic [PW-1:0] prescale;
  logic [N-1:0]  Q;
  logic          busy;
  logic          tc;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  up_counter_ctrl #(
    .N  (N),
    .PW (PW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .halt     (halt),
    .periodic (periodic),
    .limit    (limit),
    .prescale (prescale),
    .Q        (Q),
    .busy     (busy),
    .tc       (tc),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic per, input int lim, input int psc_val);
    periodic = per;
    limit    = lim[N-1:0];
    prescale = psc_val[PW-1:0];
  endtask

  initial begin
    int tc_seen;
    reset_n  = 1'b0;
    start    = 1'b0;
    halt     = 1'b0;
    periodic = 1'b0;
    limit    = '0;
    prescale = '0;

    // 1. Reset and idle.
    #2 reset_n = 1'b1;
    check("rst_q", Q, 0);
    check("rst_busy", busy, 0);
    check("rst_tc", tc, 0);
    check("rst_done", done, 0);
    repeat (3) step();
    check("idle_q", Q, 0);
    check("idle_busy", busy, 0);

    // 2. One-shot, limit=5, prescale=0.
    configure(1'b0, 5, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("os_busy", busy, 1);
    check("os_q0", Q, 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("os_q", Q, i);
      check("os_tc_pre", tc, 0);
    end
    step();
    check("os_tc", tc, 1);
    check("os_done", done, 1);
    check("os_busy_end", busy, 0);
    check("os_q_end", Q, 5);
    repeat (3) step();
    check("os_tc_once", tc, 0);
    check("os_q_hold", Q, 5);
    check("os_done_hold", done, 1);

    // 3. Periodic, limit=3, prescale=2, restarted from DONE.
    configure(1'b1, 3, 2);
    start = 1'b1;
    step();
    start = 1'b0;
    configure(1'b0, 9, 7);  // must be ignored while busy
    check("per_busy", busy, 1);
    check("per_done", done, 0);
    check("per_q0", Q, 0);
    tc_seen = 0;
    for (int j = 1; j <= 24; j++) begin
      step();
      check("per_q", Q, (j / 3) % 4);
      check("per_tc", tc, (j % 12 == 0) ? 1 : 0);
      if (tc) tc_seen++;
    end
    check("per_tc_count", tc_seen, 2);
    check("per_done_low", done, 0);

    // 4. Pause at Q=2, resume, then halt twice to abort.
    repeat (6) step();
    check("pz_q_before", Q, 2);
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("pz_busy", busy, 1);
    check("pz_q", Q, 2);
    for (int i = 0; i < 10; i++) begin
      step();
      check("pz_hold_q", Q, 2);
      check("pz_hold_busy", busy, 1);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    check("rs_q0", Q, 2);
    repeat (2) step();
    check("rs_q2", Q, 2);
    step();
    check("rs_q3", Q, 3);
    halt = 1'b1;
    step();
    check("ab_pause_busy", busy, 1);
    check("ab_pause_q", Q, 3);
    step();
    halt = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_q", Q, 0);

    // 5a. limit=15 one-shot: reach all-ones, no wrap.
    configure(1'b0, 15, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (15) step();
    check("max_q", Q, 15);
    check("max_tc_pre", tc, 0);
    step();
    check("max_tc", tc, 1);
    check("max_done", done, 1);
    repeat (3) step();
    check("max_q_hold", Q, 15);
    check("max_done_hold", done, 1);
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("max_abort_q", Q, 0);
    check("max_abort_done", done, 0);
    check("max_abort_busy", busy, 0);

    // 5b. limit=0 periodic: tc on every tick, Q stays 0.
    configure(1'b1, 0, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    limit = 4'd5;  // must not take effect
    for (int i = 0; i < 4; i++) begin
      step();
      check("z_tc", tc, 1);
      check("z_q", Q, 0);
      check("z_busy", busy, 1);
    end
    halt = 1'b1;
    repeat (2) step();
    halt = 1'b0;
    check("z_idle_busy", busy, 0);

    // 6a. Async reset mid-run at Q=7.
    configure(1'b0, 10, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    check("ar_q7", Q, 7);
    #2 reset_n = 1'b0;
    #1;
    check("ar_q", Q, 0);
    check("ar_busy", busy, 0);
    #2 reset_n = 1'b1;
    step();
    check("ar_stay_idle", busy, 0);

    // 6b. start and halt together in IDLE: halt wins.
    start = 1'b1;
    halt  = 1'b1;
    step();
    start = 1'b0;
    halt  = 1'b0;
    check("pri_busy", busy, 0);
    check("pri_q", Q, 0);
    repeat (2) step();
    check("pri_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_up_counter_ctrl
